// File: rtl/uart_mmio_if.sv
// Data-memory request/response channel between the core and the UART responder.
interface uart_mmio_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped UART responder: TX FIFO drained onto the simulator byte port, RX fetched on RBR reads.
// Optional THR-empty interrupt (tx_irq, IER at offset 1) enabled by defining UART_TX_IRQ_EN.
module uart_mmio #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned TX_GAP    = 0
) (
  input  logic       clock,
  input  logic       reset,
  uart_mmio_if.slave bus,
  output logic       io_uart_out_valid,
  output logic [7:0] io_uart_out_ch,
  output logic       io_uart_in_valid,
  input  logic [7:0] io_uart_in_ch
`ifdef UART_TX_IRQ_EN
  ,
  output logic       tx_irq
`endif
);

  localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX_REQ = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [GAP_W-1:0] gap_q;

  logic        hit, is_rbr, is_thr, is_lsr;
  logic        fifo_full, fifo_empty, tx_idle;
  logic        accept, push, pop, in_valid_d;
  logic [2:0]  offset;
  logic [7:0]  lsr;
  logic [63:0] read_val, rdata_d;
  logic        unused_bits;

  // Address decode for the 8-byte register window
  always_comb begin
    hit    = (bus.req_addr[63:3] == BASE_ADDR[63:3]);
    offset = bus.req_addr[2:0];
    is_rbr = hit & (offset == 3'd0) & ~bus.req_wen;
    is_thr = hit & (offset == 3'd0) & bus.req_wen & bus.req_wmask[0];
    is_lsr = hit & (offset == 3'd5) & ~bus.req_wen;
  end

  assign fifo_full  = (count_q == CNT_W'(TX_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx_idle    = (gap_q == '0);
  assign lsr        = {1'b0, fifo_empty & tx_idle, ~fifo_full, 4'b0000, 1'b1};

  // A THR store against a full FIFO is held off; no same-cycle pop bypass
  assign bus.req_ready = (state_q == IDLE) & ~reset & ~(is_thr & fifo_full);
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = accept & is_thr;
  assign pop           = ~fifo_empty & tx_idle;

`ifdef UART_TX_IRQ_EN
  logic ier_q;
  logic is_ier_wr, is_ier_rd;
  assign is_ier_wr   = hit & (offset == 3'd1) & bus.req_wen & bus.req_wmask[1];
  assign is_ier_rd   = hit & (offset == 3'd1) & ~bus.req_wen;
  assign unused_bits = ^{bus.req_wdata[63:10], bus.req_wdata[8], bus.req_wmask[7:2]};
`else
  assign unused_bits = ^{bus.req_wdata[63:8], bus.req_wmask[7:1]};
`endif

  // Lane-aligned read data for every load except RBR
  always_comb begin
    read_val = '0;
    if (is_lsr) read_val[47:40] = lsr;
`ifdef UART_TX_IRQ_EN
    if (is_ier_rd) read_val[15:8] = {6'b0, ier_q, 1'b0};
`endif
  end

  always_comb begin
    state_d    = state_q;
    in_valid_d = 1'b0;
    rdata_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_rbr) begin
            state_d    = RX_REQ;
            in_valid_d = 1'b1;
          end else begin
            state_d = RESP;
            rdata_d = read_val;
          end
        end
      end
      RX_REQ: begin
        state_d = RESP;
        rdata_d = {56'b0, io_uart_in_ch};
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      io_uart_in_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.resp_valid   <= (state_d == RESP);
      bus.resp_rdata   <= rdata_d;
      io_uart_in_valid <= in_valid_d;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= bus.req_wdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      gap_q             <= '0;
      io_uart_out_valid <= 1'b0;
      io_uart_out_ch    <= 8'h00;
    end else begin
      io_uart_out_valid <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
        io_uart_out_ch <= mem[rd_ptr_q];
        gap_q          <= GAP_W'(TX_GAP);
      end else if (!tx_idle) begin
        gap_q <= gap_q - GAP_W'(1);
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ier_q  <= 1'b0;
      tx_irq <= 1'b0;
    end else begin
      if (accept && is_ier_wr) ier_q <= bus.req_wdata[9];
      tx_irq <= ier_q & fifo_empty;
    end
  end
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: randomized requests against a timing model of the TX path.
module tb_uart_mmio;
  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int          DEPTH = 8;
  localparam int          GAP   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_uart_out_valid;
  logic [7:0] io_uart_out_ch;
  logic       io_uart_in_valid;
  logic [7:0] io_uart_in_ch = 8'h00;
`ifdef UART_TX_IRQ_EN
  logic       tx_irq;
`endif

  uart_mmio_if bus ();

  uart_mmio #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .TX_GAP(GAP)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .io_uart_out_valid(io_uart_out_valid),
    .io_uart_out_ch   (io_uart_out_ch),
    .io_uart_in_valid (io_uart_in_valid),
    .io_uart_in_ch    (io_uart_in_ch)
`ifdef UART_TX_IRQ_EN
    ,
    .tx_irq           (tx_irq)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Every transmitted byte with the cycle it was on the wire
  int         obs_cyc[$];
  logic [7:0] obs_ch[$];
  always @(negedge clock) begin
    if (io_uart_out_valid === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_ch.push_back(io_uart_out_ch);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  // Model: byte i pushed at end of cycle m_acc[i], on the wire in cycle m_out[i]
  int         m_acc[$];
  int         m_out[$];
  logic [7:0] m_ch[$];
  int         m_chk = 0;
  int         obs_rd = 0;

  function automatic int count_at(input int c);
    int n = 0;
    foreach (m_acc[i]) if (m_acc[i] < c) n++;
    foreach (m_out[i]) if (m_out[i] <= c) n--;
    return n;
  endfunction

  function automatic bit tx_busy(input int c);
    foreach (m_out[i]) if (m_out[i] <= c && c < m_out[i] + GAP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] lsr_exp(input int c);
    logic [7:0] b;
    int n;
    n = count_at(c);
    b = 8'h01;
    if (n < DEPTH) b[5] = 1'b1;
    if (n == 0 && !tx_busy(c)) b[6] = 1'b1;
    return {16'h0, b, 40'h0};
  endfunction

  // Present one request, wait for its response (bounded), report timing
  task automatic do_req(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, output int pres, output int acc, output int rsp,
                        output logic [63:0] rdata, output int n_in, output int in_at);
    acc = -1; rsp = -1; n_in = 0; in_at = -1; rdata = '0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wmask = wmask;
    pres = cyc;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (acc < 0 && bus.req_ready === 1'b1) acc = cyc;
      if (io_uart_in_valid === 1'b1) begin n_in++; in_at = cyc; end
      if (bus.resp_valid === 1'b1) begin rsp = cyc; rdata = bus.resp_rdata; end
      if (rsp >= 0) break;
      @(negedge clock);
      if (acc >= 0) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic thr_store(input logic [7:0] b);
    int pres, acc, rsp, n_in, in_at, exp_acc, o;
    logic [63:0] wd, rd;
    logic [7:0]  msk;
    wd = {$urandom, $urandom}; wd[7:0] = b;
    msk = 8'($urandom) | 8'h01;
    do_req(1'b1, BASE, wd, msk, pres, acc, rsp, rd, n_in, in_at);
    exp_acc = pres;
    while (count_at(exp_acc) >= DEPTH && exp_acc < pres + 5000) exp_acc++;
    n_chk++; if (acc !== exp_acc) $display("FAIL thr_accept: got cycle %0d expected %0d", acc, exp_acc); else n_pass++;
    n_chk++; if (rsp !== exp_acc + 1) $display("FAIL thr_latency: got cycle %0d expected %0d", rsp, exp_acc + 1); else n_pass++;
    n_chk++; if (rd !== 64'h0 || n_in != 0 || in_at != -1) $display("FAIL thr_side: rdata %h in_pulses %0d expected 0/0", rd, n_in); else n_pass++;
    o = exp_acc + 2;
    if (m_out.size() > 0 && m_out[$] + GAP + 1 > o) o = m_out[$] + GAP + 1;
    m_acc.push_back(exp_acc); m_out.push_back(o); m_ch.push_back(b);
  endtask

  task automatic test_drain();
    int tgt, n_new, n_exp;
    tgt = cyc + 10;
    if (m_out.size() > m_chk && m_out[$] + 3 > tgt) tgt = m_out[$] + 3;
    while (cyc < tgt) @(negedge clock);
    #1;
    n_new = obs_cyc.size() - obs_rd;
    n_exp = m_out.size() - m_chk;
    n_chk++; if (n_new != n_exp) $display("FAIL drain_count: got %0d bytes expected %0d", n_new, n_exp); else n_pass++;
    for (int j = 0; j < n_new && j < n_exp; j++) begin
      n_chk++;
      if (obs_cyc[obs_rd+j] != m_out[m_chk+j] || obs_ch[obs_rd+j] !== m_ch[m_chk+j])
        $display("FAIL drain_byte%0d: got %h at cycle %0d expected %h at cycle %0d", j,
                 obs_ch[obs_rd+j], obs_cyc[obs_rd+j], m_ch[m_chk+j], m_out[m_chk+j]);
      else n_pass++;
    end
    obs_rd = obs_cyc.size();
    m_chk  = m_out.size();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    n_chk++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus.req_ready); else n_pass++;
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); else n_pass++;
    n_chk++; if (bus.resp_rdata !== 64'h0) $display("FAIL rst_rdata: got %h expected 0", bus.resp_rdata); else n_pass++;
    n_chk++; if (io_uart_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", io_uart_out_valid); else n_pass++;
    n_chk++; if (io_uart_out_ch !== 8'h00) $display("FAIL rst_out_ch: got %h expected 00", io_uart_out_ch); else n_pass++;
    n_chk++; if (io_uart_in_valid !== 1'b0) $display("FAIL rst_in_valid: got %b expected 0", io_uart_in_valid); else n_pass++;
`ifdef UART_TX_IRQ_EN
    n_chk++; if (tx_irq !== 1'b0) $display("FAIL rst_tx_irq: got %b expected 0", tx_irq); else n_pass++;
`endif
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #1;
    n_chk++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_lsr_idle();
    int pres, acc, rsp, n_in, in_at;
    logic [63:0] rd;
    do_req(1'b0, BASE + 64'd5, 64'h0, 8'h00, pres, acc, rsp, rd, n_in, in_at);
    n_chk++; if (acc !== pres || rsp !== pres + 1) $display("FAIL lsr_idle_timing: acc %0d resp %0d expected %0d %0d", acc, rsp, pres, pres + 1); else n_pass++;
    n_chk++; if (rd !== 64'h0000_6100_0000_0000) $display("FAIL lsr_idle_data: got %h expected 0000610000000000", rd); else n_pass++;
    n_chk++; if (n_in != 0 || in_at != -1) $display("FAIL lsr_idle_rx: got %0d pulses expected 0", n_in); else n_pass++;
  endtask

  task automatic test_rbr();
    int pres, acc, rsp, n_in, in_at;
    logic [63:0] rd;
    logic [7:0]  ch;
    for (int i = 0; i < 4; i++) begin
      ch = (i == 0) ? 8'h5A : (i == 1) ? 8'hFF : 8'($urandom);
      io_uart_in_ch = ch;
      do_req(1'b0, BASE, {$urandom, $urandom}, 8'($urandom), pres, acc, rsp, rd, n_in, in_at);
      n_chk++; if (acc !== pres || rsp !== pres + 2) $display("FAIL rbr_timing%0d: acc %0d resp %0d expected %0d %0d", i, acc, rsp, pres, pres + 2); else n_pass++;
      n_chk++; if (n_in != 1 || in_at != pres + 1) $display("FAIL rbr_in_valid%0d: got %0d pulses at %0d expected 1 at %0d", i, n_in, in_at, pres + 1); else n_pass++;
      n_chk++; if (rd !== {56'h0, ch}) $display("FAIL rbr_data%0d: got %h expected %h", i, rd, {56'h0, ch}); else n_pass++;
    end
  endtask

  task automatic test_thr_basic();
    thr_store(8'h41);
    thr_store(8'h42);
    test_drain();
  endtask

  task automatic test_miss();
    int pres, acc, rsp, n_in, in_at;
    logic [63:0] rd;
    int offs[$];
    offs = {2, 3, 4, 6, 7};
`ifndef UART_TX_IRQ_EN
    offs.push_back(1);
`endif
    do_req(1'b1, BASE + 64'd8, {$urandom, $urandom}, 8'hFF, pres, acc, rsp, rd, n_in, in_at);
    n_chk++; if (rsp !== pres + 1 || rd !== 64'h0) $display("FAIL miss_store: resp %0d data %h expected %0d 0", rsp, rd, pres + 1); else n_pass++;
    do_req(1'b0, BASE + 64'd16, 64'h0, 8'h00, pres, acc, rsp, rd, n_in, in_at);
    n_chk++; if (rsp !== pres + 1 || rd !== 64'h0 || n_in != 0) $display("FAIL miss_load: resp %0d data %h expected %0d 0", rsp, rd, pres + 1); else n_pass++;
    do_req(1'b0, BASE ^ 64'h0000_0100_0000_0005, 64'h0, 8'h00, pres, acc, rsp, rd, n_in, in_at);
    n_chk++; if (rd !== 64'h0 || n_in != 0 || in_at != -1) $display("FAIL miss_high: data %h expected 0", rd); else n_pass++;
    do_req(1'b1, BASE, {$urandom, $urandom}, 8'hFE, pres, acc, rsp, rd, n_in, in_at);
    n_chk++; if (rsp !== pres + 1) $display("FAIL unmasked_thr: resp %0d expected %0d", rsp, pres + 1); else n_pass++;
    foreach (offs[i]) begin
      do_req(1'b1, BASE + 64'(offs[i]), {$urandom, $urandom}, 8'hFF, pres, acc, rsp, rd, n_in, in_at);
      do_req(1'b0, BASE + 64'(offs[i]), 64'h0, 8'h00, pres, acc, rsp, rd, n_in, in_at);
      n_chk++; if (rsp !== pres + 1 || rd !== 64'h0) $display("FAIL unmapped_off%0d: resp %0d data %h expected %0d 0", offs[i], rsp, rd, pres + 1); else n_pass++;
    end
    test_drain();
  endtask

  task automatic test_fill();
    int pres, acc, rsp, n_in, in_at;
    logic [63:0] rd, ex;
    for (int i = 0; i < 17; i++) begin
      if (i == 16 || $urandom_range(0, 5) == 0) begin
        do_req(1'b0, BASE + 64'd5, 64'h0, 8'h00, pres, acc, rsp, rd, n_in, in_at);
        ex = lsr_exp(pres);
        n_chk++; if (acc !== pres || rsp !== pres + 1 || rd !== ex) $display("FAIL fill_lsr%0d: data %h resp %0d expected %h %0d", i, rd, rsp, ex, pres + 1); else n_pass++;
      end
      if (i < 16) thr_store(8'($urandom));
    end
    test_drain();
  endtask

  task automatic test_reset_mid();
    int a, ne, no, nresp;
    bit rdy_ok;
    for (int i = 0; i < 5; i++) thr_store(8'($urandom));
    @(negedge clock);
    io_uart_in_ch = 8'h77;
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = BASE; bus.req_wmask = 8'h00;
    #1; a = cyc;
    n_chk++; if (bus.req_ready !== 1'b1) $display("FAIL mid_rbr_ready: got %b expected 1", bus.req_ready); else n_pass++;
    @(negedge clock);
    bus.req_valid = 1'b0;
    #1;
    n_chk++; if (io_uart_in_valid !== 1'b1) $display("FAIL mid_rx_req: in_valid %b expected 1", io_uart_in_valid); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (bus.req_ready !== 1'b0 || io_uart_out_valid !== 1'b0 || io_uart_in_valid !== 1'b0)
      $display("FAIL mid_async_clear: ready %b out_valid %b in_valid %b expected 0 0 0", bus.req_ready, io_uart_out_valid, io_uart_in_valid);
    else n_pass++;
    ne = 0; no = 0;
    while (m_chk + ne < m_out.size() && m_out[m_chk+ne] <= a) ne++;
    while (obs_rd + no < obs_cyc.size() && obs_cyc[obs_rd+no] <= a) no++;
    n_chk++; if (no != ne) $display("FAIL mid_pre_count: got %0d bytes expected %0d", no, ne); else n_pass++;
    for (int j = 0; j < no && j < ne; j++) begin
      n_chk++;
      if (obs_cyc[obs_rd+j] != m_out[m_chk+j] || obs_ch[obs_rd+j] !== m_ch[m_chk+j])
        $display("FAIL mid_pre_byte%0d: got %h expected %h", j, obs_ch[obs_rd+j], m_ch[m_chk+j]);
      else n_pass++;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    m_acc.delete(); m_out.delete(); m_ch.delete(); m_chk = 0;
    obs_rd = obs_cyc.size();
    nresp = 0; rdy_ok = 1'b1;
    repeat (40) begin
      @(negedge clock); #1;
      if (bus.resp_valid === 1'b1) nresp++;
      if (bus.req_ready !== 1'b1) rdy_ok = 1'b0;
    end
    n_chk++; if (nresp != 0) $display("FAIL mid_no_resp: got %0d responses expected 0", nresp); else n_pass++;
    n_chk++; if (obs_cyc.size() != obs_rd) $display("FAIL mid_no_tx: got %0d bytes expected 0", obs_cyc.size() - obs_rd); else n_pass++;
    n_chk++; if (!rdy_ok) $display("FAIL mid_ready_after: req_ready %b expected 1", rdy_ok); else n_pass++;
    test_lsr_idle();
    thr_store(8'h33);
    test_drain();
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq();
    int pres, acc, rsp, n_in, in_at;
    logic [63:0] rd;
    do_req(1'b1, BASE + 64'd1, 64'h200, 8'h02, pres, acc, rsp, rd, n_in, in_at);
    repeat (3) @(negedge clock); #1;
    n_chk++; if (tx_irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", tx_irq); else n_pass++;
    do_req(1'b0, BASE + 64'd1, 64'h0, 8'h00, pres, acc, rsp, rd, n_in, in_at);
    n_chk++; if (rd !== 64'h200) $display("FAIL ier_read: got %h expected 200", rd); else n_pass++;
    do_req(1'b1, BASE + 64'd1, 64'h0, 8'h02, pres, acc, rsp, rd, n_in, in_at);
    repeat (3) @(negedge clock); #1;
    n_chk++; if (tx_irq !== 1'b0) $display("FAIL irq_clear: got %b expected 0", tx_irq); else n_pass++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wmask = '0;
    test_reset();
    test_lsr_idle();
    test_rbr();
    test_thr_basic();
    test_miss();
    test_fill();
    test_reset_mid();
`ifdef UART_TX_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
